// File: rtl/seq_multiplier.sv
// ============================================================================
// Module   : seq_multiplier
// Brief    : Multi-cycle shift-add multiplier for the EX stage; one product bit
//            per clock, WIDTH steps per multiply, HI/LO result held until the
//            next completion. Optional signed mode under `MULT_SIGNED_EN`.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultStart,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             MultSigned,
  output logic             Busy,
  output logic             countdone,
  output logic             ProdV,
  output logic [WIDTH-1:0] ProdHi,
  output logic [WIDTH-1:0] ProdLo
);

  localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [c_CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_accStep;
  logic [2*WIDTH-1:0]   w_product;
  logic [WIDTH-1:0]     w_opA;
  logic [WIDTH-1:0]     w_opB;
  logic                 w_start;
  logic                 w_final;

  // A new multiply may be accepted from IDLE or straight out of DONE.
  assign w_start = MultStart && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_final = (r_state == S_RUN) && (r_count == c_LAST);

  // One shift-add step; the extra sum bit keeps the carry that shifts into the MSB.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand & {WIDTH{r_acc[0]}}};
  assign w_accStep = {w_sum, r_acc[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
  logic w_negStart;
  logic r_neg;

  assign w_opA      = (MultSigned && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
  assign w_opB      = (MultSigned && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
  assign w_negStart = MultSigned && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
  assign w_product  = r_neg ? -w_accStep : w_accStep;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_neg <= 1'b0;
    end else if (w_start) begin
      r_neg <= w_negStart;
    end
  end
`else
  logic w_unusedSigned;

  assign w_unusedSigned = MultSigned;
  assign w_opA          = SrcAE;
  assign w_opB          = SrcBE;
  assign w_product      = w_accStep;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    Busy        = 1'b0;
    countdone   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MultStart) w_nextState = S_RUN;
      end
      S_RUN: begin
        Busy = 1'b1;
        if (r_count == c_LAST) begin
          countdone   = 1'b1;
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_nextState = MultStart ? S_RUN : S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      ProdV   <= 1'b0;
      ProdHi  <= '0;
      ProdLo  <= '0;
    end else begin
      ProdV <= 1'b0;
      if (w_start) begin
        r_mcand <= w_opA;
        r_acc   <= {{WIDTH{1'b0}}, w_opB};
        r_count <= '0;
      end else if (r_state == S_RUN) begin
        r_acc   <= w_accStep;
        r_count <= r_count + c_ONE;
        if (w_final) begin
          ProdHi <= w_product[2*WIDTH-1:WIDTH];
          ProdLo <= w_product[WIDTH-1:0];
          ProdV  <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: fixed vector table, random operands
// against an arithmetic reference, and hand-written hold/abort/back-to-back runs.
`default_nettype none

module tb_seq_multiplier;

  localparam int W = 32;
`ifdef MULT_SIGNED_EN
  localparam bit c_SIGNED = 1'b1;
`else
  localparam bit c_SIGNED = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          MultStart;
  logic [W-1:0]  SrcAE;
  logic [W-1:0]  SrcBE;
  logic          MultSigned;
  logic          Busy;
  logic          countdone;
  logic          ProdV;
  logic [W-1:0]  ProdHi;
  logic [W-1:0]  ProdLo;

  int            nVec  = 0;
  int            nFail = 0;
  logic [63:0]   lastProd;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[6];

  seq_multiplier #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .MultStart  (MultStart),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .MultSigned (MultSigned),
    .Busy       (Busy),
    .countdone  (countdone),
    .ProdV      (ProdV),
    .ProdHi     (ProdHi),
    .ProdLo     (ProdLo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] p;
    if (sgn && c_SIGNED) p = 64'(longint'($signed(a)) * longint'($signed(b)));
    else                 p = {32'd0, a} * {32'd0, b};
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic startOp(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    MultStart  = 1'b1;
    SrcAE      = a;
    SrcBE      = b;
    MultSigned = sgn;
  endtask

  // Called right after the start edge has been armed; ends on the negedge of the DONE cycle.
  task automatic trackOp(input logic [63:0] exp, input logic [63:0] prev, input bit hold, input string tag);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      if (hold) begin
        SrcAE      = $urandom;
        SrcBE      = $urandom;
        MultSigned = 1'($urandom_range(0, 1));
      end else begin
        MultStart = 1'b0;
      end
      check($sformatf("%s status cyc%0d", tag, k), 64'({Busy, countdone, ProdV}),
            64'({1'b1, (k == W - 1), 1'b0}));
      check($sformatf("%s stable cyc%0d", tag, k), {ProdHi, ProdLo}, prev);
    end
    @(negedge clk);
    check($sformatf("%s done status", tag), 64'({Busy, countdone, ProdV}), 64'(3'b001));
    check($sformatf("%s product", tag), {ProdHi, ProdLo}, exp);
  endtask

  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input logic [63:0] exp, input string tag);
    @(negedge clk);
    check($sformatf("%s idle status", tag), 64'({Busy, countdone, ProdV}), 64'(0));
    startOp(a, b, sgn);
    trackOp(exp, lastProd, 1'b0, tag);
    lastProd = exp;
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    bit          sawBad;

    tbl[0] = '{32'd3,        32'd5,        1'b0, 64'h00000000_0000000F, "3x5"};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, "maxsq"};
    tbl[2] = '{32'hFFFFFFFE, 32'd3,        1'b1,
               c_SIGNED ? 64'hFFFFFFFF_FFFFFFFA : 64'h00000002_FFFFFFFA, "neg2x3"};
    tbl[3] = '{32'd0,        32'hDEADBEEF, 1'b0, 64'h0,                 "zero"};
    tbl[4] = '{32'd1,        32'hFFFFFFFF, 1'b0, 64'h00000000_FFFFFFFF, "onexmax"};
    tbl[5] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, "minsq"};

    reset = 1'b1; MultStart = 1'b0; SrcAE = '0; SrcBE = '0; MultSigned = 1'b0;
    lastProd = 64'h0;
    @(negedge clk);
    @(negedge clk);
    check("reset status", 64'({Busy, countdone, ProdV}), 64'(0));
    check("reset product", {ProdHi, ProdLo}, 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) runOp(tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].exp, tbl[i].name);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'hFFFFFFFF;
        1: b = 32'h80000000;
        2: a = 32'h0;
        default: ;
      endcase
      s = 1'($urandom_range(0, 1));
      runOp(a, b, s, model(a, b, s), $sformatf("rand%0d", i));
    end

    // MultStart held through RUN with changing operands, then a new op from DONE.
    @(negedge clk);
    startOp(32'd11, 32'd13, 1'b0);
    trackOp(64'd143, lastProd, 1'b1, "hold");
    startOp(32'd2, 32'd9, 1'b0);
    trackOp(64'd18, 64'd143, 1'b0, "hold-next");
    lastProd = 64'd18;

    // Reset in the middle of RUN aborts the multiply.
    @(negedge clk);
    startOp(32'h0000FFFF, 32'h0000FFFF, 1'b0);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      MultStart = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("abort status", 64'({Busy, countdone, ProdV}), 64'(0));
    check("abort product", {ProdHi, ProdLo}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    lastProd = 64'h0;
    sawBad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ProdV || Busy) sawBad = 1'b1;
    end
    check("abort no ProdV", 64'(sawBad), 64'(0));
    runOp(32'd7, 32'd6, 1'b0, 64'd42, "7x6");

    // Back-to-back: second request is presented during DONE.
    runOp(32'd4, 32'd4, 1'b0, 64'd16, "4x4");
    startOp(32'd2, 32'd9, 1'b0);
    trackOp(64'd18, 64'd16, 1'b0, "b2b");
    lastProd = 64'd18;
    @(negedge clk);
    check("b2b idle", 64'({Busy, countdone, ProdV}), 64'(0));
    check("b2b held", {ProdHi, ProdLo}, 64'd18);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

`default_nettype wire
